cic_interp_up: RTL and testbench

//  N-stage CIC interpolator (xR): final stage of the TX upsampler chain, after hb_up and comp_up.

---
 rtl/cic_interp_up.sv | 166 ++++++++++++++++
 tb/tb_cic_interp_up.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_interp_up.sv
// rtl/cic_interp_up.sv - N-stage CIC interpolator (xRATE) pulling low-rate samples via in_req/in_valid.
// Optional CIC_UP_ROUND_EN: round half up before the output shift instead of flooring.
module cic_interp_up #(
  parameter int DW_IN          = 16,
  parameter int DW_OUT         = 12,
  parameter int N_STAGES       = 4,
  parameter int RATE           = 1625,
  parameter int REGISTER_WIDTH = 56,
  parameter int OUT_SHIFT      = 36
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_enable,
  input  logic signed [DW_IN-1:0]  filter_in,
  input  logic                     in_valid,
  output logic                     in_req,
  output logic signed [DW_OUT-1:0] filter_out,
  output logic                     ce_out,
  output logic                     underrun,
  output logic                     overrun
);
  localparam int PW = $clog2(RATE);
  localparam int RW = REGISTER_WIDTH;
  localparam logic [PW-1:0] PHASE_LAST  = PW'(RATE - 1);
  localparam logic [PW-1:0] PHASE_STUFF = PW'(1);
  localparam logic signed [RW-1:0] SAT_MAX = RW'((2 ** (DW_OUT - 1)) - 1);
  localparam logic signed [RW-1:0] SAT_MIN = ~SAT_MAX;
`ifdef CIC_UP_ROUND_EN
  localparam logic signed [RW-1:0] ROUND_ADD = RW'(1) << (OUT_SHIFT - 1);
`endif

  logic [PW-1:0]            phase_q, phase_d;
  logic signed [DW_IN-1:0]  buf_q, buf_d;
  logic signed [DW_IN-1:0]  last_q, last_d;
  logic                     pending_q, pending_d;
  logic                     underrun_q, underrun_d;
  logic                     overrun_q, overrun_d;
  logic                     in_req_q, in_req_d;
  logic                     ce_out_q, ce_out_d;
  logic signed [RW-1:0]     dly_q [N_STAGES];
  logic signed [RW-1:0]     dly_d [N_STAGES];
  logic signed [RW-1:0]     comb_q, comb_d;
  logic signed [RW-1:0]     integ_q [N_STAGES];
  logic signed [RW-1:0]     integ_d [N_STAGES];
  logic signed [DW_OUT-1:0] out_q, out_d;

  logic                     consume;
  logic signed [DW_IN-1:0]  comb_src;
  logic signed [RW-1:0]     diff [N_STAGES+1];
  logic signed [RW-1:0]     pre;
  logic signed [RW-1:0]     shifted;
  logic signed [DW_OUT-1:0] sat_val;

  // The comb cascade is combinational off the delay registers; only its final result is registered.
  always_comb begin
    comb_src = pending_q ? buf_q : last_q;
    diff[0]  = {{(RW-DW_IN){comb_src[DW_IN-1]}}, comb_src};
    for (int i = 0; i < N_STAGES; i++) begin
      diff[i+1] = diff[i] - dly_q[i];
    end
  end

  always_comb begin
    pre = integ_q[N_STAGES-1];
`ifdef CIC_UP_ROUND_EN
    pre = integ_q[N_STAGES-1] + ROUND_ADD;
`endif
    shifted = pre >>> OUT_SHIFT;
    if (shifted > SAT_MAX) begin
      sat_val = SAT_MAX[DW_OUT-1:0];
    end else if (shifted < SAT_MIN) begin
      sat_val = SAT_MIN[DW_OUT-1:0];
    end else begin
      sat_val = shifted[DW_OUT-1:0];
    end
  end

  always_comb begin
    phase_d    = phase_q;
    buf_d      = buf_q;
    last_d     = last_q;
    pending_d  = pending_q;
    underrun_d = underrun_q;
    overrun_d  = overrun_q;
    comb_d     = comb_q;
    out_d      = out_q;
    for (int i = 0; i < N_STAGES; i++) begin
      dly_d[i]   = dly_q[i];
      integ_d[i] = integ_q[i];
    end
    consume  = clk_enable && (phase_q == '0);
    in_req_d = consume;
    ce_out_d = clk_enable;

    if (clk_enable) begin
      phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + PW'(1);
      if (phase_q == '0) begin
        for (int i = 0; i < N_STAGES; i++) begin
          dly_d[i] = diff[i];
        end
        comb_d = diff[N_STAGES];
        if (pending_q) begin
          last_d    = buf_q;
          pending_d = 1'b0;
        end else begin
          underrun_d = 1'b1;
        end
      end
      // Zero stuffing: the comb result enters the integrators once, on the cycle after phase 0.
      integ_d[0] = integ_q[0] + ((phase_q == PHASE_STUFF) ? comb_q : '0);
      for (int i = 1; i < N_STAGES; i++) begin
        integ_d[i] = integ_q[i] + integ_q[i-1];
      end
      out_d = sat_val;
    end

    // A same-cycle consume empties the slot first, so the new sample is not an overrun.
    if (in_valid) begin
      buf_d     = filter_in;
      pending_d = 1'b1;
      if (pending_q && !consume) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q    <= '0;
      buf_q      <= '0;
      last_q     <= '0;
      pending_q  <= 1'b0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
      in_req_q   <= 1'b0;
      ce_out_q   <= 1'b0;
      comb_q     <= '0;
      out_q      <= '0;
      for (int i = 0; i < N_STAGES; i++) begin
        dly_q[i]   <= '0;
        integ_q[i] <= '0;
      end
    end else begin
      phase_q    <= phase_d;
      buf_q      <= buf_d;
      last_q     <= last_d;
      pending_q  <= pending_d;
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
      in_req_q   <= in_req_d;
      ce_out_q   <= ce_out_d;
      comb_q     <= comb_d;
      out_q      <= out_d;
      for (int i = 0; i < N_STAGES; i++) begin
        dly_q[i]   <= dly_d[i];
        integ_q[i] <= integ_d[i];
      end
    end
  end

  assign in_req     = in_req_q;
  assign ce_out     = ce_out_q;
  assign filter_out = out_q;
  assign underrun   = underrun_q;
  assign overrun    = overrun_q;
endmodule

// File: tb/tb_cic_interp_up.sv
// tb/tb_cic_interp_up.sv - randomized self-checking bench for cic_interp_up against a sequence-level CIC model.
module tb_cic_interp_up;
  localparam int N = 4;
  localparam int R = 1625;
  localparam int SH = 36;
`ifdef CIC_UP_ROUND_EN
  localparam logic [11:0] DC_NEG_EXP = 12'hC01;
`else
  localparam logic [11:0] DC_NEG_EXP = 12'hC00;
`endif

  logic clk = 1'b0;
  logic reset, clk_enable, in_valid, in_req, ce_out, underrun, overrun;
  logic signed [15:0] filter_in;
  logic signed [11:0] filter_out;

  always #5 clk = ~clk;

  cic_interp_up dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .filter_in(filter_in),
    .in_valid(in_valid), .in_req(in_req), .filter_out(filter_out),
    .ce_out(ce_out), .underrun(underrun), .overrun(overrun)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: low-rate sample history, N-th difference by binomial sum,
  // zero-stuffed high-rate sequence, N-fold running sum, N+1 cycle output delay.
  longint e_cnt;
  longint xh [N+1];
  longint acc [N];
  longint yd [N+2];
  logic signed [15:0] pend_val;
  bit pend_has;
  logic [11:0] exp_out;
  bit exp_ce, exp_req, exp_under, exp_over;

  int resp_cd;
  bit resp_en, resp_rand;
  logic signed [15:0] resp_val, resp_dc;

  function automatic longint binom(input int n, input int k);
    longint r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  function automatic logic [11:0] sat_out(input longint y);
    longint v = (y <<< 8) >>> 8;
`ifdef CIC_UP_ROUND_EN
    v = v + (longint'(1) <<< (SH - 1));
    v = (v <<< 8) >>> 8;
`endif
    v = v >>> SH;
    if (v > 2047) v = 2047;
    else if (v < -2048) v = -2048;
    return v[11:0];
  endfunction

  task automatic model_reset;
    e_cnt = 0;
    for (int j = 0; j <= N; j++) xh[j] = 0;
    for (int j = 0; j < N; j++) acc[j] = 0;
    for (int j = 0; j < N + 2; j++) yd[j] = 0;
    pend_has = 0; pend_val = 0;
    exp_out = 0; exp_ce = 0; exp_req = 0; exp_under = 0; exp_over = 0;
    resp_cd = 0;
  endtask

  task automatic step(input bit en, input bit vld, input logic signed [15:0] d);
    longint c, u, xnew;
    clk_enable = en; in_valid = vld; filter_in = d;
    @(posedge clk);
    exp_ce = en;
    exp_req = 0;
    if (en) begin
      u = 0;
      if (e_cnt % R == 0) begin
        exp_req = 1;
        if (pend_has) begin xnew = longint'(pend_val); pend_has = 0; end
        else begin xnew = xh[0]; exp_under = 1; end
        for (int j = N; j > 0; j--) xh[j] = xh[j-1];
        xh[0] = xnew;
        c = 0;
        for (int j = 0; j <= N; j++) c += ((j % 2) ? -1 : 1) * binom(N, j) * xh[j];
        u = c;
      end
      acc[0] += u;
      for (int i = 1; i < N; i++) acc[i] += acc[i-1];
      for (int j = N + 1; j > 0; j--) yd[j] = yd[j-1];
      yd[0] = acc[N-1];
      exp_out = sat_out(yd[N+1]);
      e_cnt++;
    end
    if (vld) begin
      if (pend_has) exp_over = 1;
      pend_val = d;
      pend_has = 1;
    end
    #1;
  endtask

  task automatic tick(input bit en);
    bit vld = 0;
    if (resp_cd > 0) begin
      resp_cd--;
      vld = (resp_cd == 0);
    end
    step(en, vld, vld ? resp_val : 16'($urandom()));
    if (in_req === 1'b1 && resp_en) begin
      resp_cd = $urandom_range(1, 400);
      resp_val = resp_rand ? 16'($urandom()) : resp_dc;
    end
  endtask

  task automatic apply_reset;
    reset = 1; clk_enable = 1; in_valid = 1; filter_in = 16'sh1234;
    @(posedge clk);
    model_reset();
    #1;
    reset = 0; clk_enable = 0; in_valid = 0;
  endtask

  task automatic test_reset;
    apply_reset();
    checks += 5;
    if (in_req !== 1'b0) begin errors++; $display("FAIL reset_in_req got=%b exp=0", in_req); end
    if (ce_out !== 1'b0) begin errors++; $display("FAIL reset_ce_out got=%b exp=0", ce_out); end
    if (filter_out !== 12'h000) begin errors++; $display("FAIL reset_filter_out got=%h exp=000", filter_out); end
    if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
    if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_cadence;
    int n_req = 0;
    longint first = -1, prev = -1, e;
    bit spacing_ok = 1;
    apply_reset();
    resp_en = 1; resp_rand = 0; resp_dc = 16'sh4000;
    step(1'b0, 1'b1, 16'sh4000);
    for (int i = 0; i < 4 * R; i++) begin
      e = e_cnt;
      tick(1'b1);
      checks += 2;
      if (ce_out !== exp_ce) begin errors++; $display("FAIL cad_ce_out got=%b exp=%b e=%0d", ce_out, exp_ce, e); end
      if (in_req !== exp_req) begin errors++; $display("FAIL cad_in_req got=%b exp=%b e=%0d", in_req, exp_req, e); end
      if (exp_ce) begin
        checks++;
        if (filter_out !== exp_out) begin errors++; $display("FAIL cad_filter_out got=%h exp=%h e=%0d", filter_out, exp_out, e); end
      end
      if (in_req === 1'b1) begin
        n_req++;
        if (first < 0) first = e;
        if (prev >= 0 && e - prev != R) spacing_ok = 0;
        prev = e;
      end
    end
    checks += 4;
    if (n_req != 4) begin errors++; $display("FAIL cad_count got=%0d exp=4", n_req); end
    if (first != 0) begin errors++; $display("FAIL cad_first got=%0d exp=0", first); end
    if (!spacing_ok) begin errors++; $display("FAIL cad_spacing got=irregular exp=%0d", R); end
    if (underrun !== 1'b0) begin errors++; $display("FAIL cad_underrun got=%b exp=0", underrun); end
  endtask

  task automatic test_dc_pos;
    for (int i = 0; i < 3 * R; i++) begin
      tick(1'b1);
      if (exp_ce) begin
        checks++;
        if (filter_out !== exp_out) begin errors++; $display("FAIL dcp_filter_out got=%h exp=%h e=%0d", filter_out, exp_out, e_cnt); end
      end
    end
    checks += 2;
    if (filter_out !== 12'h3FF) begin errors++; $display("FAIL dcp_settled got=%h exp=3FF", filter_out); end
    if (overrun !== 1'b0) begin errors++; $display("FAIL dcp_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_underrun;
    bit skipped = 0;
    checks++;
    if (underrun !== 1'b0) begin errors++; $display("FAIL und_before got=%b exp=0", underrun); end
    for (int i = 0; i < 3 * R; i++) begin
      tick(1'b1);
      if (in_req === 1'b1 && !skipped) begin
        resp_cd = 0;
        skipped = 1;
      end
      if (ce_out === 1'b1) begin
        checks++;
        if (filter_out !== 12'h3FF) begin errors++; $display("FAIL und_hold got=%h exp=3FF e=%0d", filter_out, e_cnt); end
      end
    end
    checks += 2;
    if (underrun !== 1'b1) begin errors++; $display("FAIL und_flag got=%b exp=1", underrun); end
    if (overrun !== 1'b0) begin errors++; $display("FAIL und_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_dc_neg;
    apply_reset();
    resp_en = 1; resp_rand = 0; resp_dc = -16'sh4000;
    for (int i = 0; i < 7 * R; i++) tick(1'b1);
    checks += 2;
    if (filter_out !== DC_NEG_EXP) begin errors++; $display("FAIL dcn_settled got=%h exp=%h", filter_out, DC_NEG_EXP); end
    if (filter_out !== exp_out) begin errors++; $display("FAIL dcn_model got=%h exp=%h", filter_out, exp_out); end
  endtask

  task automatic test_overrun_gaps;
    int n_req = 0, cyc = 0;
    bit en;
    apply_reset();
    resp_en = 1; resp_rand = 1;
    while (e_cnt < 4 * R && cyc < 40000) begin
      en = ($urandom_range(0, 99) < 30);
      tick(en);
      cyc++;
      checks += 2;
      if (ce_out !== exp_ce) begin errors++; $display("FAIL gap_ce_out got=%b exp=%b e=%0d", ce_out, exp_ce, e_cnt); end
      if (in_req !== exp_req) begin errors++; $display("FAIL gap_in_req got=%b exp=%b e=%0d", in_req, exp_req, e_cnt); end
      if (exp_ce) begin
        checks++;
        if (filter_out !== exp_out) begin errors++; $display("FAIL gap_filter_out got=%h exp=%h e=%0d", filter_out, exp_out, e_cnt); end
      end
      if (in_req === 1'b1) begin
        n_req++;
        if (n_req == 2) begin
          checks++;
          if (overrun !== 1'b0) begin errors++; $display("FAIL gap_overrun_early got=%b exp=0", overrun); end
          resp_cd = 0;
          step($urandom_range(0, 99) < 30, 1'b1, 16'sh1000);
          step($urandom_range(0, 99) < 30, 1'b0, 16'($urandom()));
          step($urandom_range(0, 99) < 30, 1'b1, 16'sh2000);
          checks++;
          if (overrun !== 1'b1) begin errors++; $display("FAIL gap_overrun got=%b exp=1", overrun); end
        end
      end
    end
    checks++;
    if (e_cnt < 4 * R) begin errors++; $display("FAIL gap_timeout got=%0d exp=%0d enabled cycles", e_cnt, 4 * R); end
  endtask

  task automatic test_reset_mid;
    int cyc = 0;
    apply_reset();
    resp_en = 1; resp_rand = 1;
    while (!(e_cnt % R == 800 && e_cnt > R) && cyc < 3 * R) begin
      tick(1'b1);
      cyc++;
    end
    checks++;
    if (e_cnt % R != 800) begin errors++; $display("FAIL mid_reach got=%0d exp=800", e_cnt % R); end
    apply_reset();
    checks += 5;
    if (in_req !== 1'b0) begin errors++; $display("FAIL mid_in_req got=%b exp=0", in_req); end
    if (ce_out !== 1'b0) begin errors++; $display("FAIL mid_ce_out got=%b exp=0", ce_out); end
    if (filter_out !== 12'h000) begin errors++; $display("FAIL mid_filter_out got=%h exp=000", filter_out); end
    if (underrun !== 1'b0) begin errors++; $display("FAIL mid_underrun got=%b exp=0", underrun); end
    if (overrun !== 1'b0) begin errors++; $display("FAIL mid_overrun got=%b exp=0", overrun); end
    step(1'b1, 1'b0, 16'sh0000);
    checks += 2;
    if (in_req !== 1'b1) begin errors++; $display("FAIL mid_req_after got=%b exp=1", in_req); end
    if (ce_out !== 1'b1) begin errors++; $display("FAIL mid_ce_after got=%b exp=1", ce_out); end
  endtask

  initial begin
    reset = 1; clk_enable = 0; in_valid = 0; filter_in = 0;
    resp_en = 0; resp_rand = 0; resp_dc = 0; resp_val = 0;
    model_reset();
    test_reset();
    test_cadence();
    test_dc_pos();
    test_underrun();
    test_dc_neg();
    test_overrun_gaps();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
